// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
// Counter encoding, reset/allocate values and PC step.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RST   = WNT;
    localparam ctr_t CTR_ALLOC = WT;
    localparam int   PC_INC    = 4;

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating direction counter update.
// Jumps force the counter straight to strongly taken.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic up,
    input  logic force_st,
    output ctr_t nxt
);

    // next counter value: force, saturating increment or decrement
    always_comb begin
        nxt = ctr;
        if (force_st) begin
            nxt = ST;
        end else if (up) begin
            nxt = (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with EX-stage resolution.
// Optional counters built only when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] branch_predict_pc,
    output logic             branch_taken,
    input  logic             ex_stall,
    input  logic             ex_br_valid,
    input  logic             ex_is_jump,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] ex_pred_pc,
    input  logic             ex_actual_taken,
    input  logic [WIDTH-1:0] ex_actual_target,
    output logic             branch_miss,
    output logic [WIDTH-1:0] branch_miss_pc,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_misses
);

    localparam int TAG_W = WIDTH - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [WIDTH-1:0]   tgt_q [ENTRIES];
    ctr_t               ctr_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             miss_raw;
    logic             upd;
    logic             taken_eff;
    ctr_t             ctr_nxt;
    logic             unused_bits;

    assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[WIDTH-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[WIDTH-1:IDX_W+2];

    // fetch-side lookup; reset clears valid so taken drops at once
    always_comb begin
        if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        branch_taken = if_hit & ctr_q[if_idx][1];
        branch_predict_pc = branch_taken ? tgt_q[if_idx]
                          : if_pc + WIDTH'(PC_INC);
    end

    // resolution against the prediction carried down the pipe
    always_comb begin
        miss_raw = (ex_pred_taken != ex_actual_taken)
                 | (ex_actual_taken & (ex_pred_pc != ex_actual_target));
        branch_miss = rst_n & ex_br_valid & miss_raw;
        branch_miss_pc = ex_actual_taken ? ex_actual_target
                       : ex_pc + WIDTH'(PC_INC);
    end

    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign upd       = ex_br_valid & ~ex_stall;
    assign taken_eff = ex_actual_taken | ex_is_jump;

    bp_sat_counter u_ctr (
        .ctr      (ctr_q[ex_idx]),
        .up       (ex_actual_taken),
        .force_st (ex_is_jump),
        .nxt      (ctr_nxt)
    );

    // table update on unstalled resolution; whole-entry writes only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_RST;
            end
        end else if (upd) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_nxt;
                if (taken_eff) tgt_q[ex_idx] <= ex_actual_target;
            end else if (taken_eff) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= ex_actual_target;
                ctr_q[ex_idx]   <= ex_is_jump ? ST : CTR_ALLOC;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] ms_cnt_q;

    // resolved-branch and misprediction counters, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            ms_cnt_q <= '0;
        end else if (upd) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (miss_raw) ms_cnt_q <= ms_cnt_q + 32'd1;
        end
    end

    assign stat_branches = br_cnt_q;
    assign stat_misses   = ms_cnt_q;
`else
    assign stat_branches = '0;
    assign stat_misses   = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed checks of branch_predictor
// against a table-level behavioural model.
module tb_branch_predictor;

    localparam int W  = 32;
    localparam int N  = 64;
    localparam int IW = 6;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  if_pc;
    logic [W-1:0]  branch_predict_pc;
    logic          branch_taken;
    logic          ex_stall;
    logic          ex_br_valid;
    logic          ex_is_jump;
    logic [W-1:0]  ex_pc;
    logic          ex_pred_taken;
    logic [W-1:0]  ex_pred_pc;
    logic          ex_actual_taken;
    logic [W-1:0]  ex_actual_target;
    logic          branch_miss;
    logic [W-1:0]  branch_miss_pc;
    logic [31:0]   stat_branches;
    logic [31:0]   stat_misses;

    branch_predictor #(.WIDTH(W), .ENTRIES(N), .IDX_W(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .branch_predict_pc(branch_predict_pc),
        .branch_taken     (branch_taken),
        .ex_stall         (ex_stall),
        .ex_br_valid      (ex_br_valid),
        .ex_is_jump       (ex_is_jump),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_pc       (ex_pred_pc),
        .ex_actual_taken  (ex_actual_taken),
        .ex_actual_target (ex_actual_target),
        .branch_miss      (branch_miss),
        .branch_miss_pc   (branch_miss_pc),
        .stat_branches    (stat_branches),
        .stat_misses      (stat_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: one record per set, counter as a plain 0..3 integer
    bit          m_v   [N];
    int unsigned m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];
    int unsigned m_br;
    int unsigned m_ms;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_ms = 0;
    endfunction

    function automatic void m_pred(input logic [31:0] pc,
                                   output bit tk,
                                   output logic [31:0] npc);
        int i;
        i = idx_of(pc);
        tk = m_v[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
        npc = tk ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic bit m_miss();
        if (ex_pred_taken != ex_actual_taken) return 1;
        return ex_actual_taken && ex_pred_pc != ex_actual_target;
    endfunction

    function automatic logic [31:0] m_miss_pc();
        return ex_actual_taken ? ex_actual_target : ex_pc + 32'd4;
    endfunction

    function automatic int unsigned exp_stat(input int unsigned v);
`ifdef BP_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // apply the effect of the coming edge to the model
    function automatic void m_step();
        int i;
        bit hit, tk;
        if (!rst_n || !ex_br_valid || ex_stall) return;
        i = idx_of(ex_pc);
        hit = m_v[i] && m_tag[i] == tag_of(ex_pc);
        tk = ex_actual_taken || ex_is_jump;
        m_br++;
        if (m_miss()) m_ms++;
        if (hit) begin
            if (ex_is_jump) m_ctr[i] = 3;
            else if (ex_actual_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            if (tk) m_tgt[i] = ex_actual_target;
        end else if (tk) begin
            m_v[i] = 1; m_tag[i] = tag_of(ex_pc);
            m_tgt[i] = ex_actual_target;
            m_ctr[i] = ex_is_jump ? 3 : 2;
        end
    endfunction

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input bit v, input bit j,
                            input logic [31:0] pc,
                            input bit pt, input logic [31:0] ppc,
                            input bit at, input logic [31:0] tg);
        ex_br_valid = v; ex_is_jump = j; ex_pc = pc;
        ex_pred_taken = pt; ex_pred_pc = ppc;
        ex_actual_taken = at; ex_actual_target = tg;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_stall = 1'b0;
        if_pc = 32'h100;
        drive_ex(1, 0, 32'h40, 0, 32'h44, 1, 32'h80);
        m_clear();
        #1;
        n_cmp++;
        if (branch_taken !== 1'b0) begin
            n_bad++; $display("FAIL rst_taken got %0b want 0", branch_taken);
        end
        n_cmp++;
        if (branch_predict_pc !== 32'h104) begin
            n_bad++; $display("FAIL rst_npc got %h want 00000104", branch_predict_pc);
        end
        n_cmp++;
        if (branch_miss !== 1'b0) begin
            n_bad++; $display("FAIL rst_miss got %0b want 0", branch_miss);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (stat_branches !== 32'd0 || stat_misses !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_stats got %0d/%0d want 0/0", stat_branches, stat_misses);
        end
        n_cmp++;
        if (branch_taken !== 1'b0 || branch_predict_pc !== 32'h104) begin
            n_bad++;
            $display("FAIL post_rst_lookup got %0b %h want 0 00000104",
                     branch_taken, branch_predict_pc);
        end
    endtask

    task automatic test_alloc_and_train();
        drive_ex(1, 0, 32'h100, 0, 32'h104, 1, 32'h200);
        #1;
        n_cmp++;
        if (branch_miss !== 1'b1 || branch_miss_pc !== 32'h200) begin
            n_bad++;
            $display("FAIL alloc_miss got %0b %h want 1 00000200",
                     branch_miss, branch_miss_pc);
        end
        tick();
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h100;
        #1;
        n_cmp++;
        if (branch_taken !== 1'b1 || branch_predict_pc !== 32'h200) begin
            n_bad++;
            $display("FAIL alloc_lookup got %0b %h want 1 00000200",
                     branch_taken, branch_predict_pc);
        end
        for (int k = 0; k < 3; k++) begin
            drive_ex(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
            #1;
            n_cmp++;
            if (branch_miss !== 1'b1 || branch_miss_pc !== 32'h104) begin
                n_bad++;
                $display("FAIL nt_miss%0d got %0b %h want 1 00000104",
                         k, branch_miss, branch_miss_pc);
            end
            tick();
            drive_ex(0, 0, 0, 0, 0, 0, 0);
            #1;
            n_cmp++;
            if (branch_taken !== 1'b0 || branch_predict_pc !== 32'h104) begin
                n_bad++;
                $display("FAIL nt_lookup%0d got %0b %h want 0 00000104",
                         k, branch_taken, branch_predict_pc);
            end
        end
        for (int k = 0; k < 2; k++) begin
            drive_ex(1, 0, 32'h100, 0, 32'h104, 1, 32'h200);
            tick();
            drive_ex(0, 0, 0, 0, 0, 0, 0);
            #1;
            n_cmp++;
            if (branch_taken !== (k == 1)) begin
                n_bad++;
                $display("FAIL retrain%0d got %0b want %0b", k, branch_taken, k == 1);
            end
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h100 + 32'(4 * N);
        #1;
        n_cmp++;
        if (branch_taken !== 1'b0 || branch_predict_pc !== if_pc + 32'd4) begin
            n_bad++;
            $display("FAIL alias got %0b %h want 0 %h",
                     branch_taken, branch_predict_pc, if_pc + 32'd4);
        end
        if_pc = 32'h100;
        #1;
        n_cmp++;
        if (branch_taken !== 1'b1) begin
            n_bad++; $display("FAIL alias_orig got %0b want 1", branch_taken);
        end
    endtask

    task automatic test_stall();
        int unsigned b0;
        bit tk;
        logic [31:0] npc;
        b0 = m_br;
        drive_ex(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
        ex_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (branch_miss !== 1'b1) begin
                n_bad++; $display("FAIL stall_miss%0d got %0b want 1", k, branch_miss);
            end
            tick();
        end
        n_cmp++;
        if (stat_branches !== exp_stat(b0)) begin
            n_bad++;
            $display("FAIL stall_hold got %0d want %0d", stat_branches, exp_stat(b0));
        end
        ex_stall = 1'b0;
        tick();
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (stat_branches !== exp_stat(b0 + 1)) begin
            n_bad++;
            $display("FAIL stall_once got %0d want %0d", stat_branches, exp_stat(b0 + 1));
        end
        m_pred(32'h100, tk, npc);
        if_pc = 32'h100;
        #1;
        n_cmp++;
        if (branch_taken !== tk || branch_predict_pc !== npc) begin
            n_bad++;
            $display("FAIL stall_step got %0b %h want %0b %h",
                     branch_taken, branch_predict_pc, tk, npc);
        end
    endtask

    task automatic test_random();
        bit tk;
        logic [31:0] npc, pc, tg;
        for (int c = 0; c < 400; c++) begin
            pc = 32'h1000 + 32'(4 * $urandom_range(0, 3))
               + 32'(4 * N * $urandom_range(0, 1));
            tg = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            m_pred(pc, tk, npc);
            drive_ex(($urandom_range(0, 3) != 0), 0, pc,
                     tk, ($urandom_range(0, 1) != 0) ? npc : tg,
                     ($urandom_range(0, 1) != 0), tg);
            if ($urandom_range(0, 5) == 0) begin
                ex_is_jump = 1'b1; ex_actual_taken = 1'b1;
            end
            ex_stall = ($urandom_range(0, 3) == 0);
            if_pc = 32'h1000 + 32'(4 * $urandom_range(0, 3))
                  + 32'(4 * N * $urandom_range(0, 1));
            #1;
            m_pred(if_pc, tk, npc);
            n_cmp++;
            if (branch_taken !== tk || branch_predict_pc !== npc) begin
                n_bad++;
                $display("FAIL rnd_lookup c=%0d pc=%h got %0b %h want %0b %h",
                         c, if_pc, branch_taken, branch_predict_pc, tk, npc);
            end
            n_cmp++;
            if (branch_miss !== (ex_br_valid && m_miss())
                || branch_miss_pc !== m_miss_pc()) begin
                n_bad++;
                $display("FAIL rnd_miss c=%0d got %0b %h want %0b %h", c,
                         branch_miss, branch_miss_pc,
                         ex_br_valid && m_miss(), m_miss_pc());
            end
            tick();
        end
        ex_stall = 1'b0;
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (stat_branches !== exp_stat(m_br) || stat_misses !== exp_stat(m_ms)) begin
            n_bad++;
            $display("FAIL rnd_stats got %0d/%0d want %0d/%0d", stat_branches,
                     stat_misses, exp_stat(m_br), exp_stat(m_ms));
        end
    endtask

    task automatic test_async_reset();
        drive_ex(1, 1, 32'h300, 0, 32'h304, 1, 32'h480);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h300;
        #1;
        n_cmp++;
        if (branch_taken !== 1'b1 || branch_predict_pc !== 32'h480) begin
            n_bad++;
            $display("FAIL jmp_alloc got %0b %h want 1 00000480",
                     branch_taken, branch_predict_pc);
        end
        #1;
        rst_n = 1'b0;
        m_clear();
        #1;
        n_cmp++;
        if (branch_taken !== 1'b0 || branch_predict_pc !== 32'h304) begin
            n_bad++;
            $display("FAIL async_rst got %0b %h want 0 00000304",
                     branch_taken, branch_predict_pc);
        end
        n_cmp++;
        if (stat_branches !== 32'd0 || stat_misses !== 32'd0) begin
            n_bad++;
            $display("FAIL async_stats got %0d/%0d want 0/0", stat_branches, stat_misses);
        end
        drive_ex(1, 0, 32'h300, 0, 32'h304, 1, 32'h480);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive_ex(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (branch_taken !== 1'b0 || stat_branches !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_discard got %0b %0d want 0 0",
                     branch_taken, stat_branches);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_and_train();
        test_alias();
        test_stall();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Front-end branch predictor and EX-stage resolution point for the RV32 pipeline. Each cycle it looks up the current fetch PC in a direct-mapped BTB with 2-bit saturating counters and drives `branch_predict_pc` and `branch_taken` to the IF unit. It also compares the resolved branch outcome from EX against the prediction carried down the pipe. On a mismatch it drives `branch_miss` and `branch_miss_pc` back to IF, and it updates the table.

## Interface
- `WIDTH`, 32: address/data width.
- `ENTRIES`, 64: BTB entries; power of two, minimum 4.
- `IDX_W`, 6: log2(`ENTRIES`).
- `clk`  in  1: clock, all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `if_pc`  in  `WIDTH`: current fetch PC (IF unit `pc_out`).
- `branch_predict_pc`  out  `WIDTH`: predicted next PC to IF.
- `branch_taken`  out  1: predicted taken to IF.
- `ex_stall`  in  1: EX stage stalled (ctrl stall bit for EX); blocks table/stat updates.
- `ex_br_valid`  in  1: EX holds a resolved branch or jump this cycle.
- `ex_is_jump`  in  1: EX instruction is JAL/JALR (always taken).
- `ex_pc`  in  `WIDTH`: PC of the EX instruction.
- `ex_pred_taken`  in  1: prediction carried with the instruction.
- `ex_pred_pc`  in  `WIDTH`: predicted next PC carried with the instruction.
- `ex_actual_taken`  in  1: resolved direction.
- `ex_actual_target`  in  `WIDTH`: resolved target.
- `branch_miss`  out  1: misprediction to IF.
- `branch_miss_pc`  out  `WIDTH`: corrected PC to IF.
- `stat_branches`  out  32: resolved-branch count (`BP_STATS_EN` only, else 0).
- `stat_misses`  out  32: misprediction count (`BP_STATS_EN` only, else 0).

## Operation
- Entry fields: `valid`, `tag` = PC[`WIDTH`-1:`IDX_W`+2], `target` (`WIDTH`), `ctr` (2 bits). Index = PC[`IDX_W`+1:2].
- Lookup (combinational on `if_pc`):
  - hit = valid & tag match.
  - `branch_taken` = hit & `ctr`[1].
  - `branch_predict_pc` = `branch_taken` ? `target` : `if_pc`+4 (modulo 2^`WIDTH`).
- Resolution (combinational, gated by `ex_br_valid`):
  - miss = (`ex_pred_taken` != `ex_actual_taken`) | (`ex_actual_taken` & `ex_pred_pc` != `ex_actual_target`).
  - `branch_miss_pc` = `ex_actual_taken` ? `ex_actual_target` : `ex_pc`+4.
  - `branch_miss` is asserted regardless of `ex_stall`; IF buffers it itself.
- Update, on an edge where `ex_br_valid` & !`ex_stall`:
  - Hit at `ex_pc`, jump: `ctr` forced 11, `target` written.
  - Hit at `ex_pc`, branch: `ctr` saturating +1 if taken, else -1; `target` written only if taken.
  - No hit, taken: allocate/overwrite the entry with valid=1, tag, target, `ctr`=10 (11 for jump).
  - No hit, not taken: no write.
- Same-cycle lookup and update to the same index: lookup sees pre-edge contents.
- Flush does not clear the table. Only `rst_n` does.

## Timing
- Reset (async): all valid=0, all `ctr`=01, targets 0, stats 0.
- Outputs during reset: `branch_taken`=0, `branch_predict_pc`=`if_pc`+4, `branch_miss`=0.
- Prediction and miss outputs have zero-cycle latency (combinational). Table writes are visible to lookups one cycle after the update edge.
- Reset asserted mid-update discards that update. No partial entry writes.
- `ex_br_valid` held across N stalled cycles gives exactly one update, on the first unstalled edge.

## Configuration
- `BP_STATS_EN` defined:
  - `stat_branches` increments on each updating edge.
  - `stat_misses` increments on each updating edge with miss=1.
  - Both counters wrap at 2^32.
- `BP_STATS_EN` undefined: counters are not built; both outputs are constant 0.

## Structure
- Shared package `bp_pkg`:
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - reset counter value WNT;
  - allocate value WT;
  - `PC_INC`=4.
- Sub-module `bp_sat_counter`: 2-bit saturating up/down update, with a force-to-ST input for jumps. It is instanced once, in the update path.

## Test plan
- Reset, then `if_pc`=0x100 -> `branch_taken`=0, `branch_predict_pc`=0x104.
- Taken branch resolved at `ex_pc`=0x100, target 0x200, `ex_pred_taken`=0 -> `branch_miss`=1, `branch_miss_pc`=0x200. Next cycle `if_pc`=0x100 -> taken, 0x200.
- Same branch resolved not-taken twice -> `ctr` 10→01→00. Prediction not taken, `branch_predict_pc`=0x104. Further not-taken updates saturate at 00.
- Alias: entry for 0x100 valid, lookup 0x100+4·`ENTRIES` -> tag mismatch, not taken, PC+4.
- `ex_br_valid`=1 with `ex_stall`=1 for 3 cycles, then released -> `branch_miss` is asserted each cycle, the counter changes by exactly one step, and `stat_branches` increments by 1.
- `rst_n` pulsed low asynchronously between edges after allocation -> entry is invalid immediately and stats are 0.
